// File: rtl/qpsk_seq_ctrl.sv
// Burst sequencer for a dual (I/Q) m-sequence QPSK chip generator.
// Latches generator config, issues a load strobe, then paces chips with a rate divider.
module qpsk_seq_ctrl #(
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 16,
  parameter int PERIOD = 31
) (
  input  logic             CLK_50MHZ,
  input  logic             RST,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [4:0]       cfg_seed_i,
  input  logic [4:0]       cfg_seed_q,
  input  logic [4:0]       cfg_type_i,
  input  logic [4:0]       cfg_type_q,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             start,
  input  logic             abort,
  output logic             gen_load,
  output logic [4:0]       gen_seed_i,
  output logic [4:0]       gen_seed_q,
  output logic [4:0]       gen_type_i,
  output logic [4:0]       gen_type_q,
  output logic             chip_en,
  output logic [LEN_W-1:0] chip_cnt,
  output logic             period_mark,
  output logic             busy,
  output logic             done
);

  localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [2:0] {IDLE, ARMED, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_q, div_cnt;
  logic [LEN_W-1:0] len_q;
  logic [PH_W-1:0]  phase;
  logic             xfer, div_hit, last_chip;

  always_comb begin
    cfg_ready   = (state == IDLE) || (state == ARMED);
    xfer        = cfg_valid && cfg_ready;
    gen_load    = (state == LOAD);
    busy        = (state == LOAD) || (state == RUN);
    done        = (state == DONE);
    div_hit     = (div_cnt == div_q);
    // an abort cycle never issues a chip, even if the divider lands on it
    chip_en     = (state == RUN) && div_hit && !abort;
    period_mark = chip_en && (phase == PH_W'(PERIOD - 1));
    last_chip   = chip_en && (len_q != '0) && ((chip_cnt + LEN_W'(1)) == len_q);

    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = ARMED;
      ARMED:   if (start) state_nxt = LOAD;
      LOAD:    state_nxt = abort ? ARMED : RUN;
      RUN: begin
        if (abort)          state_nxt = ARMED;
        else if (last_chip) state_nxt = DONE;
      end
      DONE:    state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state      <= IDLE;
      gen_seed_i <= 5'b00001;
      gen_seed_q <= 5'b00001;
      gen_type_i <= '0;
      gen_type_q <= '0;
      div_q      <= '0;
      len_q      <= '0;
      div_cnt    <= '0;
      chip_cnt   <= '0;
      phase      <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        // all-zero seed would lock the LFSR; substitute the minimal nonzero state
        gen_seed_i <= (cfg_seed_i == 5'b00000) ? 5'b00001 : cfg_seed_i;
        gen_seed_q <= (cfg_seed_q == 5'b00000) ? 5'b00001 : cfg_seed_q;
        gen_type_i <= cfg_type_i;
        gen_type_q <= cfg_type_q;
        div_q      <= cfg_div;
        len_q      <= cfg_len;
      end
      if (state == LOAD) begin
        div_cnt  <= '0;
        chip_cnt <= '0;
        phase    <= '0;
      end else if (state == RUN && !abort) begin
        div_cnt <= div_hit ? '0 : div_cnt + DIV_W'(1);
        if (chip_en) begin
          chip_cnt <= chip_cnt + LEN_W'(1);
          phase    <= (phase == PH_W'(PERIOD - 1)) ? '0 : phase + PH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_seq_ctrl.sv
// Self-checking bench for qpsk_seq_ctrl: chip timing is predicted arithmetically
// from the cycle offset after LOAD, against directed and randomized bursts.
module tb_qpsk_seq_ctrl;
  localparam int DIV_W  = 8;
  localparam int LEN_W  = 16;
  localparam int PERIOD = 31;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0, cfg_ready;
  logic [4:0]       cfg_seed_i = '0, cfg_seed_q = '0, cfg_type_i = '0, cfg_type_q = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             start = 1'b0, abort = 1'b0;
  logic             gen_load, chip_en, period_mark, busy, done;
  logic [4:0]       gen_seed_i, gen_seed_q, gen_type_i, gen_type_q;
  logic [LEN_W-1:0] chip_cnt;

  int errors = 0;
  int checks = 0;

  // expected generator config as seen by the outside world
  logic [4:0] m_seed_i = 5'd1, m_seed_q = 5'd1, m_type_i = '0, m_type_q = '0;

  qpsk_seq_ctrl #(.DIV_W(DIV_W), .LEN_W(LEN_W), .PERIOD(PERIOD)) dut (
    .CLK_50MHZ(clk), .RST(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_seed_i(cfg_seed_i), .cfg_seed_q(cfg_seed_q),
    .cfg_type_i(cfg_type_i), .cfg_type_q(cfg_type_q),
    .cfg_div(cfg_div), .cfg_len(cfg_len), .start(start), .abort(abort),
    .gen_load(gen_load), .gen_seed_i(gen_seed_i), .gen_seed_q(gen_seed_q),
    .gen_type_i(gen_type_i), .gen_type_q(gen_type_q), .chip_en(chip_en),
    .chip_cnt(chip_cnt), .period_mark(period_mark), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] grd(input logic [4:0] s);
    return (s == 5'd0) ? 5'd1 : s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [4:0] si, sq, ti, tq, input int div, len);
    cfg_seed_i = si; cfg_seed_q = sq; cfg_type_i = ti; cfg_type_q = tq;
    cfg_div = DIV_W'(div); cfg_len = LEN_W'(len);
  endtask

  task automatic take_model();
    m_seed_i = grd(cfg_seed_i); m_seed_q = grd(cfg_seed_q);
    m_type_i = cfg_type_i;      m_type_q = cfg_type_q;
  endtask

  task automatic do_cfg(input logic [4:0] si, sq, ti, tq, input int div, len);
    set_fields(si, sq, ti, tq, div, len);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    take_model();
  endtask

  // Starts a burst from ARMED; ctl = {cfg_ready,gen_load,chip_en,period_mark,busy,done}.
  task automatic run_burst(input int div, len, stop, input bit do_abort, with_cfg,
                           output int n_marks);
    logic [5:0]       exp_ctl;
    logic [LEN_W-1:0] exp_cnt;
    bit               ce;
    int               k_end;
    n_marks = 0;
    start = 1'b1; cfg_valid = with_cfg;
    #1;
    checks++;
    if ({cfg_ready, gen_load, busy} !== 3'b100)
      $display("FAIL burst_start ctl=%b exp=100", {cfg_ready, gen_load, busy});
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    if (with_cfg) take_model();
    k_end = stop * (div + 1);
    for (int k = 0; k <= k_end; k++) begin
      ce      = (k > 0) && (k % (div + 1) == 0);
      exp_ctl = {1'b0, (k == 0), ce, ce && ((k / (div + 1)) % PERIOD == 0), 1'b1, 1'b0};
      exp_cnt = LEN_W'((k == 0) ? 0 : (k - 1) / (div + 1));
      if (period_mark === 1'b1) n_marks++;
      checks++;
      if ({cfg_ready, gen_load, chip_en, period_mark, busy, done} !== exp_ctl) begin
        errors++;
        $display("FAIL run_ctl k=%0d ctl=%b exp=%b", k,
                 {cfg_ready, gen_load, chip_en, period_mark, busy, done}, exp_ctl);
      end
      if (k > 0) begin
        checks++;
        if (chip_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL run_cnt k=%0d chip_cnt=%0d exp=%0d", k, chip_cnt, exp_cnt);
        end
      end
      checks++;
      if ({gen_seed_i, gen_seed_q, gen_type_i, gen_type_q} !== {m_seed_i, m_seed_q, m_type_i, m_type_q}) begin
        errors++;
        $display("FAIL gen_cfg k=%0d got=%h exp=%h", k,
                 {gen_seed_i, gen_seed_q, gen_type_i, gen_type_q},
                 {m_seed_i, m_seed_q, m_type_i, m_type_q});
      end
      tick();
    end
    if (do_abort) begin
      abort = 1'b1;
      #1;
      checks++;
      if ({chip_en, busy, done} !== 3'b010) begin
        errors++;
        $display("FAIL abort_cycle ctl=%b exp=010", {chip_en, busy, done});
      end
      tick();
      abort = 1'b0;
      for (int j = 0; j < 2; j++) begin
        checks++;
        if ({cfg_ready, gen_load, chip_en, period_mark, busy, done} !== 6'b100000 ||
            chip_cnt !== LEN_W'(stop)) begin
          errors++;
          $display("FAIL after_abort j=%0d ctl=%b cnt=%0d exp ctl=100000 cnt=%0d", j,
                   {cfg_ready, gen_load, chip_en, period_mark, busy, done}, chip_cnt, stop);
        end
        tick();
      end
    end else begin
      checks++;
      if ({cfg_ready, gen_load, chip_en, period_mark, busy, done} !== 6'b000001 ||
          chip_cnt !== LEN_W'(len)) begin
        errors++;
        $display("FAIL done_cycle ctl=%b cnt=%0d exp ctl=000001 cnt=%0d",
                 {cfg_ready, gen_load, chip_en, period_mark, busy, done}, chip_cnt, len);
      end
      tick();
      checks++;
      if ({cfg_ready, gen_load, chip_en, period_mark, busy, done} !== 6'b100000 ||
          chip_cnt !== LEN_W'(len)) begin
        errors++;
        $display("FAIL armed_after_done ctl=%b cnt=%0d exp ctl=100000 cnt=%0d",
                 {cfg_ready, gen_load, chip_en, period_mark, busy, done}, chip_cnt, len);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_seed_i = 5'd1; m_seed_q = 5'd1; m_type_i = '0; m_type_q = '0;
    checks++;
    if ({cfg_ready, gen_load, chip_en, period_mark, busy, done} !== 6'b100000 ||
        chip_cnt !== '0 || {gen_seed_i, gen_seed_q, gen_type_i, gen_type_q} !== 20'h08400) begin
      errors++;
      $display("FAIL reset ctl=%b cnt=%0d gen=%h exp ctl=100000 cnt=0 gen=08400",
               {cfg_ready, gen_load, chip_en, period_mark, busy, done}, chip_cnt,
               {gen_seed_i, gen_seed_q, gen_type_i, gen_type_q});
    end
  endtask

  task automatic test_basic();
    int marks;
    do_cfg(5'b10101, 5'b00110, 5'b10101, 5'b01001, 3, 10);
    run_burst(3, 10, 10, 1'b0, 1'b0, marks);
  endtask

  task automatic test_period();
    int marks;
    do_cfg(5'd3, 5'd5, 5'd18, 5'd30, 0, 0);
    run_burst(0, 0, 2 * PERIOD, 1'b1, 1'b0, marks);
    checks++;
    if (marks !== 2) begin
      errors++;
      $display("FAIL period_marks got=%0d exp=2", marks);
    end
  endtask

  task automatic test_guard();
    test_reset();
    set_fields(5'b01110, 5'b00000, 5'b10010, 5'b11110, 2, 5);
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    take_model();
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({cfg_ready, gen_load, busy} !== 3'b100 || gen_seed_q !== 5'b00001 ||
          gen_seed_i !== 5'b01110) begin
        errors++;
        $display("FAIL guard_idle_start j=%0d ctl=%b seed_q=%b seed_i=%b exp ctl=100 seed_q=00001 seed_i=01110",
                 j, {cfg_ready, gen_load, busy}, gen_seed_q, gen_seed_i);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    int marks;
    do_cfg(5'd9, 5'd17, 5'd20, 5'd6, 1, 20);
    run_burst(1, 20, 5, 1'b1, 1'b0, marks);
  endtask

  task automatic test_reset_mid_run();
    int marks;
    do_cfg(5'd7, 5'd9, 5'd12, 5'd25, 2, 30);
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    m_seed_i = 5'd1; m_seed_q = 5'd1; m_type_i = '0; m_type_q = '0;
    checks++;
    if ({cfg_ready, gen_load, chip_en, period_mark, busy, done} !== 6'b100000 ||
        chip_cnt !== '0 || {gen_seed_i, gen_seed_q, gen_type_i, gen_type_q} !== 20'h08400) begin
      errors++;
      $display("FAIL reset_mid_run ctl=%b cnt=%0d gen=%h exp ctl=100000 cnt=0 gen=08400",
               {cfg_ready, gen_load, chip_en, period_mark, busy, done}, chip_cnt,
               {gen_seed_i, gen_seed_q, gen_type_i, gen_type_q});
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (gen_load !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_start_ignored gen_load=%b busy=%b exp 0 0", gen_load, busy);
    end
    do_cfg(5'd0, 5'd0, 5'd4, 5'd8, 0, 3);
    run_burst(0, 3, 3, 1'b0, 1'b0, marks);
  endtask

  task automatic test_back_to_back();
    int marks;
    do_cfg(5'd11, 5'd13, 5'd3, 5'd29, 2, 3);
    run_burst(2, 3, 3, 1'b0, 1'b0, marks);
    set_fields(5'd21, 5'd2, 5'd27, 5'd14, 5, 4);
    run_burst(5, 4, 4, 1'b0, 1'b1, marks);
  endtask

  task automatic test_random();
    int marks, div, len, stop;
    bit ab;
    for (int i = 0; i < 10; i++) begin
      div  = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 40));
      ab   = (len > 1) && ($urandom_range(0, 2) == 0);
      stop = ab ? int'($urandom_range(1, len - 1)) : len;
      do_cfg(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), div, len);
      run_burst(div, len, stop, ab, 1'b0, marks);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_period();
    test_guard();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
